// File: rtl/reg_poller_pkg.sv
// rtl/reg_poller_pkg.sv - shared FSM encodings, response codes and helpers for axil_reg_poller
package reg_poller_pkg;

    // Read-master FSM encodings
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         ERR_CNT_W = 8;

    // Saturating increment for the response error counter
    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/axil_reg_poller_poll_timer.sv
// rtl/axil_reg_poller_poll_timer.sv - poll period counter, poll_now/pending merge and read start strobe
module poll_timer
    import reg_poller_pkg::*;
#(
    parameter int POLL_PERIOD = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic poll_en_i,
    input  logic poll_now_i,
    input  logic idle_i,
    output logic start_o
);

    localparam int            TW   = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0] LAST = TW'(POLL_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;

    // A read may only start from IDLE; a periodic expiry, a direct request or a
    // request remembered while busy all trigger it.
    assign start_o = idle_i && ((poll_en_i && (timer_q == LAST)) || poll_now_i || pending_q);

    // Next-state for the period counter and the one-deep request latch
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        if (start_o) begin
            timer_d = '0;
        end else if (!poll_en_i) begin
            timer_d = '0;
        end else if (timer_q != LAST) begin
            // The period keeps running during a transaction so reads stay
            // POLL_PERIOD apart; it parks at LAST if the bus is still busy.
            timer_d = timer_q + 1'b1;
        end

        if (start_o) begin
            pending_d = 1'b0;
        end else if (poll_now_i && !idle_i) begin
            pending_d = 1'b1;
        end
    end

    // Timer resets to LAST so the first read goes out right after reset release
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q   <= LAST;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/axil_reg_poller.sv
// rtl/axil_reg_poller.sv - AXI4-Lite read-only poller; optional value_ts under REG_POLLER_TIMESTAMP_EN
module axil_reg_poller
    import reg_poller_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 1,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] POLL_ADDR          = '0,
    parameter int                            POLL_PERIOD        = 1000,
    parameter int                            TIMEOUT_CYCLES     = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          poll_en,
    input  logic                          poll_now,
    input  logic                          err_clear,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic                          M_AXI_AWVALID,
    output logic                          M_AXI_WVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] value,
    output logic                          value_valid,
    output logic                          value_changed,
    output logic                          err_resp,
    output logic                          err_timeout,
    output logic [ERR_CNT_W-1:0]          err_count
`ifdef REG_POLLER_TIMESTAMP_EN
    ,
    output logic [31:0]                   value_ts
`endif
);

    localparam int            FW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] TO_MAX = FW'(TIMEOUT_CYCLES);

    state_e                        state_q;
    logic                          arvalid_q;
    logic                          rready_q;
    logic [FW-1:0]                 inflight_q, inflight_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] value_q;
    logic                          value_valid_q;
    logic                          value_changed_q;
    logic                          err_resp_q, err_resp_d;
    logic                          err_timeout_q, err_timeout_d;
    logic [ERR_CNT_W-1:0]          err_count_q, err_count_d;

    logic start;
    logic rd_done;
    logic ok_done;
    logic err_done;
    logic timeout_hit;

    // Write channels are never used; B is always accepted so a stray response cannot stall
    assign M_AXI_ARADDR  = POLL_ADDR;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    assign value         = value_q;
    assign value_valid   = value_valid_q;
    assign value_changed = value_changed_q;
    assign err_resp      = err_resp_q;
    assign err_timeout   = err_timeout_q;
    assign err_count     = err_count_q;

    poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk_i      (M_AXI_ACLK),
        .rst_i      (M_AXI_ARESET),
        .poll_en_i  (poll_en),
        .poll_now_i (poll_now),
        .idle_i     (state_q == IDLE),
        .start_o    (start)
    );

    assign rd_done  = (state_q == R) && rready_q && M_AXI_RVALID;
    assign ok_done  = rd_done && (M_AXI_RRESP == RESP_OKAY);
    assign err_done = rd_done && (M_AXI_RRESP != RESP_OKAY);

    // The in-flight counter saturates at TO_MAX, so this fires once per transaction
    assign timeout_hit = (state_q != IDLE) && (inflight_q == (TO_MAX - 1'b1));
    assign inflight_d  = (inflight_q == TO_MAX) ? inflight_q : inflight_q + 1'b1;

    // Sticky error flags: a new event in the same cycle as err_clear wins
    always_comb begin
        err_resp_d    = err_done | (err_resp_q & ~err_clear);
        err_timeout_d = timeout_hit | (err_timeout_q & ~err_clear);
        err_count_d   = err_count_q;
        if (err_clear) begin
            err_count_d = err_done ? ERR_CNT_W'(1) : '0;
        end else if (err_done) begin
            err_count_d = err_cnt_inc(err_count_q);
        end
    end

    // Read FSM with registered ARVALID/RREADY; a started transaction always runs to completion
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q    <= IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            inflight_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= AR;
                        arvalid_q  <= 1'b1;
                        inflight_q <= '0;
                    end
                end
                AR: begin
                    inflight_q <= inflight_d;
                    if (M_AXI_ARREADY) begin
                        state_q   <= R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                R: begin
                    inflight_q <= inflight_d;
                    if (M_AXI_RVALID) begin
                        state_q  <= IDLE;
                        rready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Latest OKAY value, validity and change pulse, plus error status registers
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            value_q         <= '0;
            value_valid_q   <= 1'b0;
            value_changed_q <= 1'b0;
            err_resp_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_count_q     <= '0;
        end else begin
            value_changed_q <= 1'b0;
            if (ok_done) begin
                value_q         <= M_AXI_RDATA;
                value_valid_q   <= 1'b1;
                value_changed_q <= !value_valid_q || (M_AXI_RDATA != value_q);
            end
            err_resp_q    <= err_resp_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

`ifdef REG_POLLER_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] value_ts_q;

    assign value_ts = value_ts_q;

    // Free-running cycle counter, sampled on every OKAY completion
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            ts_q       <= '0;
            value_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (ok_done) begin
                value_ts_q <= ts_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_reg_poller.sv
// tb/tb_axil_reg_poller.sv - directed self-checking bench for axil_reg_poller
module tb_axil_reg_poller;

    logic        clk = 1'b0;
    logic        rst;
    logic        poll_en, poll_now, err_clear;
    logic [0:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready, awvalid, wvalid, bready;
    logic [31:0] value;
    logic        value_valid, value_changed, err_resp, err_timeout;
    logic [7:0]  err_count;
`ifdef REG_POLLER_TIMESTAMP_EN
    logic [31:0] value_ts;
`endif

    int checks   = 0;
    int failures = 0;

    // Slave model knobs
    logic        ar_ready_en;
    logic [31:0] cur_data;
    logic [1:0]  cur_resp;
    int          r_wait;
    int          r_cnt;
    int          ar_hs_cnt = 0;

    always #5 clk = ~clk;

    axil_reg_poller #(
        .C_M_AXI_ADDR_WIDTH (1),
        .C_M_AXI_DATA_WIDTH (32),
        .POLL_PERIOD        (8),
        .TIMEOUT_CYCLES     (256)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .poll_en       (poll_en),
        .poll_now      (poll_now),
        .err_clear     (err_clear),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_BREADY  (bready),
        .value         (value),
        .value_valid   (value_valid),
        .value_changed (value_changed),
        .err_resp      (err_resp),
        .err_timeout   (err_timeout),
        .err_count     (err_count)
`ifdef REG_POLLER_TIMESTAMP_EN
        ,
        .value_ts      (value_ts)
`endif
    );

    assign arready = ar_ready_en;

    // Slave: RVALID one cycle after AR handshake when r_wait==0, else r_wait cycles later
    always @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            r_cnt  <= 0;
            rdata  <= '0;
            rresp  <= '0;
        end else begin
            if (arvalid && arready) begin
                rdata     <= cur_data;
                rresp     <= cur_resp;
                ar_hs_cnt <= ar_hs_cnt + 1;
                if (r_wait == 0) rvalid <= 1'b1;
                else r_cnt <= r_wait;
            end else if (r_cnt != 0) begin
                r_cnt <= r_cnt - 1;
                if (r_cnt == 1) rvalid <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic issue_read(input logic [31:0] d, input logic [1:0] r, output int pulses);
        cur_data = d;
        cur_resp = r;
        pulses   = 0;
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (value_changed) pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; poll_en = 1'b0; poll_now = 1'b0; err_clear = 1'b0;
        ar_ready_en = 1'b1; cur_data = 32'h5A5A_0001; cur_resp = 2'b00; r_wait = 0;
        repeat (3) @(negedge clk);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b expected 0", rready); end
        checks++; if (value !== 32'h0) begin failures++; $display("FAIL reset_value: got %h expected 0", value); end
        checks++; if (value_valid !== 1'b0 || value_changed !== 1'b0) begin failures++; $display("FAIL reset_valid_changed: got %b%b expected 00", value_valid, value_changed); end
        checks++; if (err_resp !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_flags: got %b%b expected 00", err_resp, err_timeout); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        checks++; if (araddr !== 1'b0 || arprot !== 3'b000) begin failures++; $display("FAIL ar_constants: got addr %b prot %b expected 0 000", araddr, arprot); end
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin failures++; $display("FAIL write_ties: got aw%b w%b b%b expected 0 0 1", awvalid, wvalid, bready); end
    endtask

    task automatic test_first_read();
        bit seen;
        rst = 1'b0; poll_en = 1'b1;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL first_arvalid: got %b expected 1", arvalid); end
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin failures++; $display("FAIL first_r_phase: got arvalid %b rready %b expected 0 1", arvalid, rready); end
        @(negedge clk);
        checks++; if (value !== 32'h5A5A_0001) begin failures++; $display("FAIL first_value: got %h expected 5a5a0001", value); end
        checks++; if (value_valid !== 1'b1 || value_changed !== 1'b1) begin failures++; $display("FAIL first_valid_changed: got %b%b expected 11", value_valid, value_changed); end
        @(negedge clk);
        checks++; if (value_changed !== 1'b0) begin failures++; $display("FAIL changed_one_cycle: got %b expected 0", value_changed); end
        seen = arvalid;
        repeat (4) begin
            @(negedge clk);
            if (arvalid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL period_early: got arvalid %b expected 0", seen); end
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL period_8: got arvalid %b expected 1", arvalid); end
        poll_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_value_change();
        int p;
        issue_read(32'h5A5A_0001, 2'b00, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL repeat1_pulses: got %0d expected 0", p); end
        issue_read(32'h5A5A_0001, 2'b00, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL repeat2_pulses: got %0d expected 0", p); end
        issue_read(32'h5A5A_0002, 2'b00, p);
        checks++; if (p !== 1) begin failures++; $display("FAIL change_pulses: got %0d expected 1", p); end
        checks++; if (value !== 32'h5A5A_0002) begin failures++; $display("FAIL change_value: got %h expected 5a5a0002", value); end
    endtask

    task automatic test_err_resp();
        int p;
        int total = 0;
        for (int i = 0; i < 3; i++) begin
            issue_read(32'hDEAD_BEEF, 2'b10, p);
            total += p;
        end
        checks++; if (value !== 32'h5A5A_0002 || value_valid !== 1'b1) begin failures++; $display("FAIL err_value_kept: got %h/%b expected 5a5a0002/1", value, value_valid); end
        checks++; if (total !== 0) begin failures++; $display("FAIL err_no_pulse: got %0d expected 0", total); end
        checks++; if (err_resp !== 1'b1) begin failures++; $display("FAIL err_resp_set: got %b expected 1", err_resp); end
        checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL err_count_3: got %0d expected 3", err_count); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        checks++; if (err_resp !== 1'b0 || err_count !== 8'd0 || err_timeout !== 1'b0) begin failures++; $display("FAIL err_clear: got %b %0d %b expected 0 0 0", err_resp, err_count, err_timeout); end
    endtask

    task automatic test_err_collision();
        int p;
        issue_read(32'h0, 2'b10, p);
        issue_read(32'h0, 2'b11, p);
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL pre_collision_count: got %0d expected 2", err_count); end
        cur_resp = 2'b11;
        poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
        @(negedge clk);
        checks++; if (!(rvalid && rready)) begin failures++; $display("FAIL collision_r_phase: got rvalid %b rready %b expected 1 1", rvalid, rready); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        checks++; if (err_count !== 8'd1 || err_resp !== 1'b1) begin failures++; $display("FAIL clear_collision: got %0d/%b expected 1/1", err_count, err_resp); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) issue_read(32'h0, 2'b10, p);
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_count_sat: got %0d expected 255", err_count); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        checks++; if (err_count !== 8'd0 || err_resp !== 1'b0) begin failures++; $display("FAIL err_clear2: got %0d/%b expected 0/0", err_count, err_resp); end
    endtask

    task automatic test_timeout();
        ar_ready_en = 1'b0; cur_data = 32'h5A5A_0003; cur_resp = 2'b00;
        poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL to_arvalid_start: got %b expected 1", arvalid); end
        repeat (255) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early_255: got %b expected 0", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_set_256: got %b expected 1", err_timeout); end
        repeat (44) @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL to_arvalid_held: got %b expected 1", arvalid); end
        ar_ready_en = 1'b1;
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin failures++; $display("FAIL to_r_phase: got arvalid %b rready %b expected 0 1", arvalid, rready); end
        @(negedge clk);
        checks++; if (value !== 32'h5A5A_0003 || value_changed !== 1'b1) begin failures++; $display("FAIL to_completes: got %h/%b expected 5a5a0003/1", value, value_changed); end
        checks++; if (err_resp !== 1'b0 || err_timeout !== 1'b1) begin failures++; $display("FAIL to_flags: got resp %b to %b expected 0 1", err_resp, err_timeout); end
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b expected 0", err_timeout); end
    endtask

    task automatic test_pending();
        int base;
        r_wait = 4;
        base = ar_hs_cnt;
        poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
        @(negedge clk);
        checks++; if (rready !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL pend_in_r: got rready %b rvalid %b expected 1 0", rready, rvalid); end
        poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
        poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (ar_hs_cnt - base !== 2) begin failures++; $display("FAIL pend_read_count: got %0d expected 2", ar_hs_cnt - base); end
        r_wait = 0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        ar_ready_en = 1'b0; poll_en = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (arvalid) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL mid_wait_arvalid: got %b expected 1", found); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL mid_reset_drop: got arvalid %b rready %b expected 0 0", arvalid, rready); end
        checks++; if (value !== 32'h0 || value_valid !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs: got %h/%b/%b expected 0/0/0", value, value_valid, err_timeout); end
        ar_ready_en = 1'b1; rst = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL mid_resume: got %b expected 1", arvalid); end
        repeat (2) @(negedge clk);
        checks++; if (value !== 32'h5A5A_0003 || value_valid !== 1'b1) begin failures++; $display("FAIL mid_resume_value: got %h/%b expected 5a5a0003/1", value, value_valid); end
        poll_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_read();
        test_value_change();
        test_err_resp();
        test_err_collision();
        test_timeout();
        test_pending();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_reg_poller.md
Name: axil_reg_poller

Overview:
- AXI4-Lite read-only master that periodically reads one 32-bit register and presents the latest value to fabric logic.
- Sits directly upstream of the USR_ACCESS build-ID slave: it drives that slave's AR channel and consumes its R channel.
- Adds software-free update detection, response-error and timeout status.

Parameters:
- C_M_AXI_ADDR_WIDTH, 1, AR address width
- C_M_AXI_DATA_WIDTH, 32, R data width; only 32 supported
- POLL_ADDR, 0, address driven on ARADDR
- POLL_PERIOD, 1000, cycles between automatic reads; must be >= 2
- TIMEOUT_CYCLES, 256, cycles in flight before the timeout flag sets

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge
- M_AXI_ARESET  in  1  synchronous, active-high reset
- poll_en  in  1  enables periodic polling
- poll_now  in  1  single-cycle request for an immediate read
- err_clear  in  1  clears sticky error flags and the error count
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  constant POLL_ADDR
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  read request valid
- M_AXI_ARREADY  in  1  read request accepted
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready
- M_AXI_AWVALID / M_AXI_WVALID  out  1  tied to 0
- M_AXI_BREADY  out  1  tied to 1
- value  out  32  last OKAY read data
- value_valid  out  1  at least one OKAY read has completed
- value_changed  out  1  one-cycle pulse when value is updated with different data, or on the first valid read
- err_resp  out  1  sticky: a non-OKAY RRESP was received
- err_timeout  out  1  sticky: a transaction exceeded TIMEOUT_CYCLES
- err_count  out  8  saturating count of non-OKAY responses

Behaviour:
- Reset values:
  - state IDLE
  - ARVALID=0, RREADY=0
  - value=0, value_valid=0, value_changed=0
  - err_resp=0, err_timeout=0, err_count=0
  - timer = POLL_PERIOD-1, so the first read issues one cycle after reset release if poll_en=1
  - pending=0
- FSM IDLE:
  - timer counts up while poll_en=1, and is held at 0 while poll_en=0.
  - A read starts when poll_en=1 and timer==POLL_PERIOD-1, or when poll_now=1, or when pending=1; the FSM then goes to AR and the timer clears to 0.
- FSM AR:
  - ARVALID=1; ARVALID stays high until ARREADY, with no retraction.
  - On ARVALID&ARREADY, go to R.
- FSM R:
  - RREADY=1.
  - On RVALID&RREADY, go to IDLE.
  - With a zero-wait slave the sequence is: ARVALID at cycle N, handshake at N, R handshake at N+1, value updated at N+2, back in IDLE at N+2.
  - Minimum spacing between reads is 3 cycles.
- Completion, RRESP=00:
  - value <= RDATA; value_valid <= 1.
  - value_changed=1 for one cycle if value_valid was 0 or RDATA != value.
- Completion, RRESP != 00:
  - value and value_valid unchanged; err_resp <= 1; err_count increments and saturates at 255.
- poll_now while in AR or R sets pending (one deep); further requests merge into it. pending clears when the next read starts.
- poll_en dropping mid-transaction: the transaction completes normally; no further periodic reads are issued.
- Timeout:
  - An in-flight counter clears on entry to AR and counts every cycle in AR or R.
  - When it reaches TIMEOUT_CYCLES, err_timeout <= 1. The transaction is not aborted (AXI compliance) and the counter saturates.
- err_clear coinciding with a new error in the same cycle: the set wins; err_count becomes 1, or 0 if the same-cycle event is only a timeout.
- Reset mid-transaction: state returns to IDLE and ARVALID/RREADY drop in the next cycle.

Optional Feature:
- Macro REG_POLLER_TIMESTAMP_EN.
- Defined: adds output value_ts[31:0]. A free-running 32-bit cycle counter wraps modulo 2^32 and is reset to 0. value_ts latches the counter on every OKAY completion; its reset value is 0.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package reg_poller_pkg holds:
  - FSM state encodings (IDLE=2'd0, AR=2'd1, R=2'd2)
  - RESP_OKAY=2'b00
  - ERR_CNT_W=8
- One natural sub-module, poll_timer: owns the period counter, the poll_now/pending merge and the start strobe.

Test Plan:
- POLL_PERIOD=8, slave returns OKAY 0x5A5A0001 with zero wait → first ARVALID 1 cycle after reset release; value=0x5A5A0001 with value_valid and value_changed pulse; next ARVALID exactly 8 cycles after the previous read start.
- Same data returned twice, then 0x5A5A0002 → no value_changed pulse on the repeat; exactly one pulse when value becomes 0x5A5A0002.
- Slave returns RRESP=2'b10 three times → value unchanged, err_resp=1, err_count=3; err_clear → all 0.
- ARREADY held low 300 cycles with TIMEOUT_CYCLES=256 → err_timeout=1 at in-flight cycle 256; ARVALID stays high; the read completes after ARREADY.
- poll_now pulsed twice while in R, poll_en=0 → exactly one extra read follows the current one, then none.
- M_AXI_ARESET asserted while in AR → ARVALID=0 the next cycle; outputs at reset values; polling resumes after release.
